// File: rtl/time_set_controller.sv
// Mode/set sequencer for the wall clock: turns debounced MODE/INC levels into
// RUN/SET_HOUR/SET_MIN/SET_SEC sequencing, increment pulses with auto-repeat, and timekeeper gating.
module time_set_controller #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_RATE   = 10_000_000,
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic [1:0] state,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       load,
  output logic       run_en,
  output logic       blink
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_e;

  localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0]   TO_PRE   = TO_W'(TIMEOUT_TICKS - 1);

  state_e            state_q, state_d;
  logic              mode_prev_q, inc_prev_q, arm_q;
  logic              rep_q, rep_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              blink_q, blink_d, load_q, load_d, run_en_q, run_en_d;
  logic              inc_hour_q, inc_min_q, inc_sec_q;
  logic              inc_hour_d, inc_min_d, inc_sec_d;
  logic              mode_edge, inc_edge, inc_pulse;

  // arm_q masks the first cycle after reset so a button held through reset gives no edge
  assign mode_edge = arm_q & btn_mode & ~mode_prev_q;
  assign inc_edge  = arm_q & btn_inc & ~inc_prev_q;

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    hold_d    = hold_q;
    to_d      = to_q;
    blink_d   = blink_q;
    load_d    = 1'b0;
    inc_pulse = 1'b0;
    if (state_q == RUN) begin
      rep_d   = 1'b0;
      hold_d  = '0;
      to_d    = '0;
      blink_d = 1'b0;
      if (mode_edge) begin
        state_d = SET_HOUR;
        blink_d = 1'b1;
      end
    end else if (mode_edge) begin
      rep_d  = 1'b0;
      hold_d = '0;
      to_d   = '0;
      if (state_q == SET_SEC) begin
        state_d = RUN;
        load_d  = 1'b1;
        blink_d = 1'b0;
      end else begin
        state_d = state_e'(state_q + 2'd1);
        blink_d = 1'b1;
      end
    end else if (tick_1hz && (to_q == TO_PRE) && !inc_edge) begin
      // set abandoned: back to RUN without loading
      state_d = RUN;
      rep_d   = 1'b0;
      hold_d  = '0;
      to_d    = '0;
      blink_d = 1'b0;
    end else begin
      if (tick_1hz) begin
        blink_d = ~blink_q;
        if (to_q < TO_MAX) to_d = to_q + 1'b1;
      end
      if (inc_edge) begin
        to_d      = '0;
        inc_pulse = 1'b1;
        hold_d    = '0;
        rep_d     = 1'b1;
      end else if (rep_q && btn_inc) begin
        if (hold_q == HOLD_PRE) begin
          inc_pulse = 1'b1;
          hold_d    = HOLD_RLD;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end else begin
        rep_d  = 1'b0;
        hold_d = '0;
      end
    end
    inc_hour_d = inc_pulse && (state_q == SET_HOUR);
    inc_min_d  = inc_pulse && (state_q == SET_MIN);
    inc_sec_d  = inc_pulse && (state_q == SET_SEC);
    run_en_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      arm_q       <= 1'b0;
      rep_q       <= 1'b0;
      hold_q      <= '0;
      to_q        <= '0;
      blink_q     <= 1'b0;
      load_q      <= 1'b0;
      run_en_q    <= 1'b1;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      arm_q       <= 1'b1;
      rep_q       <= rep_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      load_q      <= load_d;
      run_en_q    <= run_en_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
    end
  end

  assign state    = state_q;
  assign inc_hour = inc_hour_q;
  assign inc_min  = inc_min_q;
  assign inc_sec  = inc_sec_q;
  assign load     = load_q;
  assign run_en   = run_en_q;
  assign blink    = blink_q;

endmodule
